// File: rtl/mem_stage_if.sv
// Data-memory port of the LC-3b MEM stage: strobes, address and write data out,
// completion pulse and read data back.
interface mem_stage_if;
    logic        d_read;
    logic        d_write;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [1:0]  d_byte_enable;
    logic        d_resp;
    logic [15:0] d_rdata;

    modport master (
        output d_read, d_write, d_addr, d_wdata, d_byte_enable,
        input  d_resp, d_rdata
    );

    modport slave (
        input  d_read, d_write, d_addr, d_wdata, d_byte_enable,
        output d_resp, d_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// LC-3b memory-access stage: LDR/LDB/STR/STB plus the two-access LDI/STI sequence,
// stalling the pipeline until the data-memory port completes each access.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_in_valid,
    input  logic [2:0]  i_mem_op,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_store_data,
    output logic        o_stall,
    output logic [15:0] o_mem_rdata,
    output logic [15:0] o_mem_ldb,
    mem_stage_if.master dmem
);

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_LDR  = 3'b001;
    localparam logic [2:0] OP_LDB  = 3'b010;
    localparam logic [2:0] OP_STR  = 3'b011;
    localparam logic [2:0] OP_STB  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_STI  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_IND, S_ACC, S_DONE} state_t;

    state_t      r_state;
    logic        r_d_read;
    logic        r_d_write;
    logic [15:0] r_d_addr;
    logic [15:0] r_d_wdata;
    logic [1:0]  r_d_be;
    logic [15:0] r_mem_rdata;
    logic [15:0] r_mem_ldb;

    logic        w_mop;
    logic        w_ind;
    logic        w_store;
    logic        w_byte;
    logic        w_go_ind;
    logic        w_go_acc;
    logic [15:0] w_acc_a;
    logic [15:0] w_acc_addr;
    logic [15:0] w_acc_wdata;
    logic [1:0]  w_acc_be;

    always_comb begin
        w_mop   = i_in_valid && (i_mem_op != OP_NONE) && (i_mem_op != OP_RSV);
        w_ind   = (i_mem_op == OP_LDI) || (i_mem_op == OP_STI);
        w_store = (i_mem_op == OP_STR) || (i_mem_op == OP_STB) || (i_mem_op == OP_STI);
        w_byte  = (i_mem_op == OP_LDB) || (i_mem_op == OP_STB);

        w_go_ind = (r_state == S_IDLE) && w_mop && w_ind;
        w_go_acc = ((r_state == S_IDLE) && w_mop && !w_ind) ||
                   ((r_state == S_IND) && dmem.d_resp);

        // The final access of LDI/STI targets the pointer arriving on d_rdata.
        w_acc_a     = (r_state == S_IND) ? dmem.d_rdata : i_addr;
        w_acc_addr  = w_byte ? w_acc_a : {w_acc_a[15:1], 1'b0};
        w_acc_wdata = (i_mem_op == OP_STB) ? {2{i_store_data[7:0]}} : i_store_data;
        w_acc_be    = (i_mem_op == OP_STB) ? (w_acc_a[0] ? 2'b10 : 2'b01) : 2'b11;
    end

    assign o_stall = w_mop && (r_state != S_DONE);

    // r_d_addr doubles as the pointer register: on the IND response it is loaded
    // with the fetched pointer and held for the final access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_d_read    <= 1'b0;
            r_d_write   <= 1'b0;
            r_d_addr    <= '0;
            r_d_wdata   <= '0;
            r_d_be      <= 2'b00;
            r_mem_rdata <= '0;
            r_mem_ldb   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_mop) r_state <= w_ind ? S_IND : S_ACC;
                S_IND:  if (dmem.d_resp) r_state <= S_ACC;
                S_ACC:  if (dmem.d_resp) r_state <= S_DONE;
                S_DONE: r_state <= S_IDLE;
            endcase

            if (w_go_ind) begin
                r_d_read  <= 1'b1;
                r_d_write <= 1'b0;
                r_d_addr  <= {i_addr[15:1], 1'b0};
                r_d_be    <= 2'b11;
            end else if (w_go_acc) begin
                r_d_read  <= !w_store;
                r_d_write <= w_store;
                r_d_addr  <= w_acc_addr;
                r_d_wdata <= w_acc_wdata;
                r_d_be    <= w_acc_be;
            end else if ((r_state == S_ACC) && dmem.d_resp) begin
                r_d_read  <= 1'b0;
                r_d_write <= 1'b0;
                if ((i_mem_op == OP_LDR) || (i_mem_op == OP_LDI))
                    r_mem_rdata <= dmem.d_rdata;
                if (i_mem_op == OP_LDB)
                    r_mem_ldb <= {8'h00, i_addr[0] ? dmem.d_rdata[15:8] : dmem.d_rdata[7:0]};
            end
        end
    end

    assign dmem.d_read        = r_d_read;
    assign dmem.d_write       = r_d_write;
    assign dmem.d_addr        = r_d_addr;
    assign dmem.d_wdata       = r_d_wdata;
    assign dmem.d_byte_enable = r_d_be;
    assign o_mem_rdata        = r_mem_rdata;
    assign o_mem_ldb          = r_mem_ldb;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a word-array reference model predicts bus accesses,
// load results and stall lengths; a negedge monitor compares them against the DUT.
module tb_mem_stage;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          w;
    } acc_t;

    typedef struct {
        logic [15:0] rdata;
        logic [15:0] ldb;
        int          stalls;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  mem_op;
    logic [15:0] addr;
    logic [15:0] store_data;
    logic        stall;
    logic [15:0] mem_rdata;
    logic [15:0] mem_ldb;

    always #5 clk = ~clk;

    mem_stage_if dmem_if();

    mem_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_valid   (in_valid),
        .i_mem_op     (mem_op),
        .i_addr       (addr),
        .i_store_data (store_data),
        .o_stall      (stall),
        .o_mem_rdata  (mem_rdata),
        .o_mem_ldb    (mem_ldb),
        .dmem         (dmem_if)
    );

    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];
    int          cur_wait = 0;
    int          rcnt = 0;
    int          rw;
    logic        stray = 1'b0;

    int checks = 0;
    int failures = 0;

    acc_t acc_q[$];
    wb_t  wb_q[$];
    logic [15:0] m_rdata = '0;
    logic [15:0] m_ldb = '0;
    int   stall_cnt = 0;
    int   str_cnt = 0;
    acc_t mon_e;
    wb_t  mon_w;
    logic mon_mop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Memory responder: answers each strobed access after cur_wait wait cycles.
    always @(posedge clk) begin
        #2;
        dmem_if.d_resp  = 1'b0;
        dmem_if.d_rdata = 16'($urandom);
        if (!rst_n || !(dmem_if.d_read || dmem_if.d_write)) begin
            rcnt = 0;
        end else if (rcnt >= cur_wait) begin
            rcnt = 0;
            rw = int'(dmem_if.d_addr[15:1]);
            dmem_if.d_resp  = 1'b1;
            dmem_if.d_rdata = mem[rw];
            if (dmem_if.d_write) begin
                if (dmem_if.d_byte_enable[0]) mem[rw][7:0]  = dmem_if.d_wdata[7:0];
                if (dmem_if.d_byte_enable[1]) mem[rw][15:8] = dmem_if.d_wdata[15:8];
            end
        end else begin
            rcnt++;
        end
        if (stray) dmem_if.d_resp = 1'b1;
    end

    // Monitor: compares bus accesses on each response and WB results on each DONE cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_cnt = 0;
            str_cnt = 0;
        end else begin
            mon_mop = in_valid && (mem_op >= 3'd1) && (mem_op <= 3'd6);
            if (dmem_if.d_read || dmem_if.d_write) str_cnt++;
            if (dmem_if.d_resp && (dmem_if.d_read || dmem_if.d_write)) begin
                if (acc_q.size() == 0) begin
                    fail_now("acc_unexpected");
                end else begin
                    mon_e = acc_q.pop_front();
                    chk("acc_addr",   dmem_if.d_addr,        mon_e.addr);
                    chk("acc_write",  dmem_if.d_write,       mon_e.wr);
                    chk("acc_read",   dmem_if.d_read,        !mon_e.wr);
                    chk("acc_be",     dmem_if.d_byte_enable, mon_e.be);
                    if (mon_e.wr) chk("acc_wdata", dmem_if.d_wdata, mon_e.wdata);
                    chk("acc_cycles", str_cnt, mon_e.w + 1);
                end
                str_cnt = 0;
            end
            if (mon_mop) begin
                if (stall) begin
                    stall_cnt++;
                end else begin
                    chk("done_strobes", {dmem_if.d_read, dmem_if.d_write}, 0);
                    if (wb_q.size() == 0) begin
                        fail_now("wb_unexpected");
                    end else begin
                        mon_w = wb_q.pop_front();
                        chk("wb_rdata",  mem_rdata, mon_w.rdata);
                        chk("wb_ldb",    mem_ldb,   mon_w.ldb);
                        chk("wb_stalls", stall_cnt, mon_w.stalls);
                    end
                    stall_cnt = 0;
                end
            end else begin
                chk("idle_quiet", {stall, dmem_if.d_read, dmem_if.d_write}, 0);
            end
        end
    end

    // Reference model: ISA-level meaning of each memory op on a word array.
    task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] sd, input int w);
        logic [15:0] eff;
        acc_t e;
        wb_t  r;
        bit   ind;
        if (op == 3'd0 || op == 3'd7) return;
        ind = (op == 3'd5) || (op == 3'd6);
        eff = a;
        if (ind) begin
            e = '{addr: {a[15:1], 1'b0}, wr: 1'b0, wdata: 16'h0, be: 2'b11, w: w};
            acc_q.push_back(e);
            eff = ref_mem[a[15:1]];
        end
        e = '{addr: {eff[15:1], 1'b0}, wr: 1'b0, wdata: 16'h0, be: 2'b11, w: w};
        case (op)
            3'd1, 3'd5: m_rdata = ref_mem[eff[15:1]];
            3'd2: begin
                e.addr = eff;
                m_ldb = {8'h00, eff[0] ? ref_mem[eff[15:1]][15:8] : ref_mem[eff[15:1]][7:0]};
            end
            3'd3, 3'd6: begin
                e.wr = 1'b1;
                e.wdata = sd;
                ref_mem[eff[15:1]] = sd;
            end
            default: begin
                e.addr = eff;
                e.wr = 1'b1;
                e.wdata = {sd[7:0], sd[7:0]};
                e.be = eff[0] ? 2'b10 : 2'b01;
                if (eff[0]) ref_mem[eff[15:1]][15:8] = sd[7:0];
                else        ref_mem[eff[15:1]][7:0]  = sd[7:0];
            end
        endcase
        acc_q.push_back(e);
        r.rdata  = m_rdata;
        r.ldb    = m_ldb;
        r.stalls = 1 + (w + 1) + (ind ? (w + 1) : 0);
        wb_q.push_back(r);
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] sd, input int w);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        mem_op = op;
        addr = a;
        store_data = sd;
        cur_wait = w;
        model(op, a, sd, w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 200);
        if (stall) fail_now("stall_timeout");
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            mem_op = 3'($urandom);
        end
    endtask

    task automatic setmem(input logic [15:0] a, input logic [15:0] d);
        mem[a[15:1]] = d;
        ref_mem[a[15:1]] = d;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_rd"},    dmem_if.d_read, 0);
        chk({tag, "_wr"},    dmem_if.d_write, 0);
        chk({tag, "_be"},    dmem_if.d_byte_enable, 0);
        chk({tag, "_addr"},  dmem_if.d_addr, 0);
        chk({tag, "_wdata"}, dmem_if.d_wdata, 0);
        chk({tag, "_rdata"}, mem_rdata, 0);
        chk({tag, "_ldb"},   mem_ldb, 0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        mem_op = 3'd0;
        addr = '0;
        store_data = '0;
        dmem_if.d_resp = 1'b0;
        dmem_if.d_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_zero_outputs("reset");

        // Directed cases
        setmem(16'h3002, 16'hBEEF);
        issue(3'd1, 16'h3003, 16'h0, 2);
        setmem(16'h4000, 16'hA55A);
        issue(3'd2, 16'h4001, 16'h0, 0);
        issue(3'd2, 16'h4000, 16'h0, 0);
        issue(3'd4, 16'h5001, 16'h1234, 0);
        setmem(16'h6000, 16'h7000);
        setmem(16'h7000, 16'hCAFE);
        issue(3'd5, 16'h6000, 16'h0, 0);
        chk("ldi_rdata", mem_rdata, 16'hCAFE);
        issue(3'd6, 16'h6000, 16'h5678, 1);
        issue(3'd5, 16'h6000, 16'h0, 0);
        chk("sti_ldi_rdata", mem_rdata, 16'h5678);

        // Non-memory op with a stray response pulse
        @(posedge clk); #1;
        in_valid = 1'b1;
        mem_op = 3'd0;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        mem_op = 3'd7;
        @(negedge clk);
        chk("nonmem_rdata", mem_rdata, m_rdata);
        chk("nonmem_ldb",   mem_ldb,   m_ldb);
        idle(1);

        // Randomized traffic, mixing back-to-back ops and bubbles
        for (int k = 0; k < 150; k++) begin
            issue(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(1);
        chk("acc_q_drained", acc_q.size(), 0);
        chk("wb_q_drained",  wb_q.size(), 0);

        // Reset while an LDR is waiting in the final access
        @(posedge clk); #1;
        in_valid = 1'b1;
        mem_op = 3'd1;
        addr = 16'h2222;
        cur_wait = 10;
        repeat (3) @(negedge clk);
        chk("pre_reset_read", dmem_if.d_read, 1);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        acc_q.delete();
        wb_q.delete();
        m_rdata = '0;
        m_ldb = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midreset");
        cur_wait = 0;
        issue(3'd1, 16'h3003, 16'h0, 0);
        idle(2);
        chk("final_q_drained", acc_q.size() + wb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the pipelined LC-3b core, between the EX/MEM pipeline register and the MEM/WB register.
- Performs LDR/LDB/STR/STB/LDI/STI accesses on the data-memory port, including the two-access indirect sequence for LDI/STI.
- Stalls the pipeline until each access completes.
- Presents the loaded word and the zero-extended load byte to MEM/WB.

Parameters:
- None. Word width is fixed at 16 bits (lc3b_word); byte lane logic assumes two lanes.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  EX/MEM holds a valid instruction
- mem_op  input  3  000 NONE, 001 LDR, 010 LDB, 011 STR, 100 STB, 101 LDI, 110 STI, 111 treated as NONE
- addr  input  16  effective address from the ALU
- store_data  input  16  SR value for stores
- stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM; hold MEM/WB
- d_read  output  1  data-memory read strobe
- d_write  output  1  data-memory write strobe
- d_addr  output  16  data-memory address
- d_wdata  output  16  data-memory write data
- d_byte_enable  output  2  write lane mask ([1]=high byte)
- d_resp  input  1  memory completion, single-cycle pulse
- d_rdata  input  16  memory read data, valid with d_resp
- mem_rdata  output  16  loaded word (LDR/LDI result) to MEM/WB
- mem_ldb  output  16  ZEXT of the selected byte (LDB result) to MEM/WB

Behaviour:
- FSM states: IDLE, IND (pointer read for LDI/STI), ACC (final access), DONE. Moore memory strobes.
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - d_read, d_write and stall go to 0; d_byte_enable goes to 00.
  - d_addr, d_wdata, mem_rdata, mem_ldb and the pointer register go to 0.
  - Reset mid-access abandons the transaction; any d_resp that follows is ignored.
- Memory-op decode: mop = in_valid and mem_op in {001..110}.
- stall = mop and (state != DONE). Combinational, so it asserts in the same cycle the op arrives.
- IDLE transitions:
  - mop and op in {LDI, STI}: go to IND.
  - other mop: go to ACC.
  - no mop: stay in IDLE, no memory activity, stall=0.
- IND:
  - d_read=1, d_addr={addr[15:1],0}.
  - On d_resp: capture d_rdata into the pointer register, go to ACC.
- ACC:
  - Access address = pointer for LDI/STI, otherwise addr.
  - Loads drive d_read=1; stores drive d_write=1.
  - On d_resp: go to DONE; loads capture their result as below.
- Address rules:
  - Word ops use d_addr={a[15:1],0} and ignore a[0].
  - Byte ops use d_addr=a.
- Write data and lane masks:
  - Word stores: d_wdata=store_data, d_byte_enable=11.
  - STB: d_wdata={store_data[7:0],store_data[7:0]}, d_byte_enable = a[0] ? 10 : 01.
  - Reads drive d_byte_enable=11.
- Load capture on d_resp in ACC:
  - LDR/LDI: mem_rdata <= d_rdata.
  - LDB: mem_ldb <= {8'h00, a[0] ? d_rdata[15:8] : d_rdata[7:0]}.
  - Non-captured outputs hold their previous values.
- DONE:
  - stall=0 for exactly one cycle; the pipeline advances and MEM/WB latches mem_rdata/mem_ldb.
  - Strobes are 0; unconditionally return to IDLE.
- Latency:
  - Zero-wait memory: 3 cycles for direct ops, 4 cycles for LDI/STI.
  - Each extra wait cycle adds one cycle of stall.
- Strobes and d_addr/d_wdata/d_byte_enable stay stable until d_resp.
- Exactly one d_resp is consumed per access.
- d_resp in IDLE or DONE is ignored.
- Upstream holds mem_op, addr and store_data stable while stall=1.
- A memory op back-to-back after DONE starts from IDLE in the next cycle, with no bubble beyond the DONE cycle.

Test Plan:
- Reset during ACC with d_read=1, rst_n low then high: all outputs 0, state IDLE, the later d_resp is ignored, stall=0.
- LDR, addr=0x3003, memory returns 0xBEEF after 2 wait cycles:
  - d_addr=0x3002 and d_read high for 3 cycles.
  - stall high for 4 cycles, then low for 1 cycle.
  - mem_rdata=0xBEEF.
- LDB, addr=0x4001, d_rdata=0xA55A, zero wait: mem_ldb=0x00A5. Repeat with addr=0x4000: mem_ldb=0x005A.
- STB, addr=0x5001, store_data=0x1234:
  - d_write=1, d_wdata=0x3434, d_byte_enable=10, d_addr=0x5001.
  - mem_rdata and mem_ldb unchanged.
- LDI, addr=0x6000, memory[0x6000]=0x7000, memory[0x7000]=0xCAFE:
  - First read at 0x6000, second read at 0x7000.
  - mem_rdata=0xCAFE, stall length 3 cycles with zero wait.
- Non-memory op (mem_op=000, in_valid=1) plus a stray d_resp pulse in IDLE: stall=0, no strobes, outputs unchanged.
